bitonic_sort_pipe: RTL
======================

Name: bitonic_sort_pipe

Overview:
- Full N-input bitonic sorting network, fully pipelined with one register bank per merge stage.
- Generalises the single first-stage compare/exchange block to any power-of-two `index` and adds run-time ascending/descending mode, signed/unsigned keys and valid/ready flow control.
- Accepts one vector per cycle and emits one fully sorted vector per cycle.
- Sits between the sample-capture buffer and the rank/median extraction logic.

Parameters:
- width, 8, key bit width (≥1).
- index, 8, number of keys per vector; power of two, ≥2; otherwise elaboration error.
- SIGNED, 0, 1 = keys compared as two's complement; 0 = unsigned.
- TAG_W, $clog2(index), tag width per element; used only with SORT_TAG_EN.

Ports:
- clk  in  1  clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  input vector valid.
- in_ready  out  1  block can accept the input vector this cycle.
- in_data  in  width x [0:index-1]  unsorted keys.
- in_desc  in  1  0 = sort ascending, 1 = descending; sampled with the vector.
- out_valid  out  1  sorted vector valid.
- out_ready  in  1  downstream accepts the output vector.
- out_data  out  width x [0:index-1]  sorted keys; element 0 is the minimum (asc) or maximum (desc).
- out_tag  out  TAG_W x [0:index-1]  original position of each output key (SORT_TAG_EN only).

Behaviour:
- L = log2(index); S = L*(L+1)/2 register stages. Stage k is the (p,q) pair for p = 0..L-1, q = p..0 in order.
- Compare rule at stage (p,q):
  - Element i (bit q of i clear) is compared with partner j = i ^ (1<<q).
  - Block direction is ascending if bit p+1 of i is 0. For the last merge (p = L-1) the whole vector is one block.
  - Final direction = block direction XOR the stage's carried desc bit.
  - Ascending: min goes to i, max to j. Descending: max goes to i, min to j.
- Ties: no swap; both positions keep their inputs unchanged.
- Comparison uses SIGNED. Keys are never modified or truncated.
- Each stage register holds data, desc and a valid bit. desc travels with its own vector, so mixed-mode back-to-back vectors are legal.
- Flow control:
  - en = out_ready | ~out_valid; in_ready = en (combinational).
  - When en = 1, all stages advance. When en = 0, all stages hold, including data, desc and valid bits.
  - Accept occurs on in_valid & in_ready. If in_valid = 0 while en = 1, a bubble (valid = 0) enters stage 1.
- Latency: exactly S cycles from accept to out_valid when never stalled. Each stalled cycle adds one. Throughput is 1 vector/cycle when out_ready is held high.
- Outputs:
  - out_valid = last-stage valid.
  - out_data and out_tag are driven from the last stage and held stable while out_valid & ~out_ready.
- Reset:
  - All valid bits, desc bits, out_data and out_tag clear to 0; out_valid = 0.
  - in_ready = 1 in the cycle after reset deasserts.
  - Reset mid-stream discards all in-flight vectors; nothing is emitted afterwards for them.
- Simultaneous accept and output handshake in one cycle is legal and lossless.
- in_data is ignored whenever in_valid & in_ready is false.

Optional Feature:
- Macro: SORT_TAG_EN.
- Defined:
  - Each element carries a TAG_W tag initialised to its input position i at stage 1.
  - Tags swap together with their keys and are reset to 0.
  - out_tag is present.
- Undefined:
  - No tag storage and no out_tag port.
  - Key datapath and timing are identical.

Decomposition:
- Shared package sort_pkg holds:
  - function num_stages(index) returning L*(L+1)/2;
  - functions stage_p(k) and stage_q(k) mapping a stage number to (p,q);
  - function partner(i,q);
  - typedef of the per-stage control struct {valid, desc}.
- One sub-module, bitonic_stage: a combinational compare/exchange layer for a given (p,q), plus its register bank with enable and synchronous reset.
  - bitonic_sort_pipe is a generate loop of S instances.

Test Plan:
- index=8, width=8, in_desc=0, in_data={7,6,5,4,3,2,1,0}, out_ready=1 -> out_valid after exactly 6 cycles with out_data={0,1,2,3,4,5,6,7}.
- Same input with in_desc=1, issued back-to-back against an ascending vector -> two consecutive outputs: {0..7}, then {7..0}. Each output's order matches its own desc bit.
- Stall: stream 10 random vectors continuously, drop out_ready for cycles 8-10 -> in_ready low those cycles, out_data stable, all 10 sorted outputs delivered in order with no loss or duplication.
- SIGNED=1, in_data={-1,127,-128,0,5,-5,3,2} ascending -> {-128,-5,-1,0,2,3,5,127}. The same bits with SIGNED=0 sort as unsigned values.
- Ties and tags (SORT_TAG_EN): in_data={4,4,4,4,1,1,9,9} ascending -> out_data={1,1,4,4,4,4,9,9}. out_tag is a permutation of 0..7, and each tag points to an input element with that value.
- Reset mid-flight: accept 3 vectors, assert rst for one cycle at cycle 2 -> no out_valid ever for those vectors. out_data=0 after reset, and a vector accepted after reset appears 6 cycles later.

Source files
------------

// File: rtl/bitonic_sort_pipe_pkg.sv
// Shared helpers for the bitonic sorting pipeline: stage numbering, partner
// index and the per-stage control word.
package sort_pkg;

    typedef struct packed {
        logic valid;
        logic desc;
    } stage_ctrl_t;

    function automatic int num_stages(int n);
        int l;
        l = $clog2(n);
        return l * (l + 1) / 2;
    endfunction

    // Stages run p = 0..L-1 with q counting down p..0 inside each merge.
    function automatic int stage_p(int k);
        int p;
        int rem;
        p   = 0;
        rem = k;
        while (rem >= p + 1) begin
            rem -= p + 1;
            p++;
        end
        return p;
    endfunction

    function automatic int stage_q(int k);
        int p;
        int rem;
        p   = 0;
        rem = k;
        while (rem >= p + 1) begin
            rem -= p + 1;
            p++;
        end
        return p - rem;
    endfunction

    function automatic int unsigned partner(int unsigned i, int unsigned q);
        return i ^ (32'd1 << q);
    endfunction

endpackage

// File: rtl/bitonic_sort_pipe_if.sv
// Valid/ready vector stream into and out of the sorter.
// out_tag exists only when SORT_TAG_EN is defined.
interface bitonic_sort_pipe_if #(
    parameter int width = 8,
    parameter int index = 8,
    parameter int TAG_W = $clog2(index)
);
    logic             in_valid;
    logic             in_ready;
    logic [width-1:0] in_data [0:index-1];
    logic             in_desc;
    logic             out_valid;
    logic             out_ready;
    logic [width-1:0] out_data [0:index-1];
`ifdef SORT_TAG_EN
    logic [TAG_W-1:0] out_tag [0:index-1];
`endif

    modport slave (
        input  in_valid, in_data, in_desc, out_ready,
        output in_ready, out_valid, out_data
`ifdef SORT_TAG_EN
        , output out_tag
`endif
    );

    modport master (
        output in_valid, in_data, in_desc, out_ready,
        input  in_ready, out_valid, out_data
`ifdef SORT_TAG_EN
        , input out_tag
`endif
    );
endinterface

// File: rtl/bitonic_sort_pipe_stage.sv
// One (p,q) compare/exchange layer of the bitonic network followed by its
// register bank. Tags follow their keys when SORT_TAG_EN is defined.
module bitonic_stage
    import sort_pkg::*;
#(
    parameter int width  = 8,
    parameter int index  = 8,
    parameter int SIGNED = 0,
    parameter int TAG_W  = 3,
    parameter int P      = 0,
    parameter int Q      = 0,
    parameter int L      = 3
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        en,
    input  stage_ctrl_t                 ctrl_in,
    input  logic [0:index-1][width-1:0] d_in,
`ifdef SORT_TAG_EN
    input  logic [0:index-1][TAG_W-1:0] tag_in,
    output logic [0:index-1][TAG_W-1:0] tag_out,
`endif
    output stage_ctrl_t                 ctrl_out,
    output logic [0:index-1][width-1:0] d_out
);

    logic [0:index-1][width-1:0] d_cx;
`ifdef SORT_TAG_EN
    logic [0:index-1][TAG_W-1:0] t_cx;
`endif

    function automatic logic greater(logic [width-1:0] a, logic [width-1:0] b);
        if (SIGNED != 0) return $signed(a) > $signed(b);
        return a > b;
    endfunction

    // down = 1 puts the larger key at the lower index; ties never swap.
    function automatic logic want_swap(logic [width-1:0] a, logic [width-1:0] b, logic down);
        return down ? greater(b, a) : greater(a, b);
    endfunction

    always_comb begin
        d_cx = d_in;
`ifdef SORT_TAG_EN
        t_cx = tag_in;
`endif
        for (int unsigned i = 0; i < index; i++) begin
            if (i[Q] == 1'b0) begin
                if (want_swap(d_in[i], d_in[partner(i, Q)],
                              ((P == L - 1) ? 1'b0 : i[P+1]) ^ ctrl_in.desc)) begin
                    d_cx[i]             = d_in[partner(i, Q)];
                    d_cx[partner(i, Q)] = d_in[i];
`ifdef SORT_TAG_EN
                    t_cx[i]             = tag_in[partner(i, Q)];
                    t_cx[partner(i, Q)] = tag_in[i];
`endif
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ctrl_out <= '0;
            d_out    <= '0;
`ifdef SORT_TAG_EN
            tag_out  <= '0;
`endif
        end else if (en) begin
            ctrl_out <= ctrl_in;
            d_out    <= d_cx;
`ifdef SORT_TAG_EN
            tag_out  <= t_cx;
`endif
        end
    end

endmodule

// File: rtl/bitonic_sort_pipe.sv
// Fully pipelined N-input bitonic sorter, one register bank per merge stage,
// with a global stall. Define SORT_TAG_EN to carry original-position tags.
module bitonic_sort_pipe
    import sort_pkg::*;
#(
    parameter int width  = 8,
    parameter int index  = 8,
    parameter int SIGNED = 0,
    parameter int TAG_W  = $clog2(index)
) (
    input logic                clk,
    input logic                rst,
    bitonic_sort_pipe_if.slave bus
);

    localparam int L = $clog2(index);
    localparam int S = num_stages(index);

    if (index < 2 || (index & (index - 1)) != 0) begin : g_bad_index
        $error("bitonic_sort_pipe: index must be a power of two >= 2");
    end

    logic                        en;
    stage_ctrl_t                 ctrl [0:S];
    logic [0:index-1][width-1:0] d    [0:S];
`ifdef SORT_TAG_EN
    logic [0:index-1][TAG_W-1:0] t    [0:S];
`endif

    assign en            = bus.out_ready | ~bus.out_valid;
    assign bus.in_ready  = en;
    assign bus.out_valid = ctrl[S].valid;
    assign ctrl[0]       = {bus.in_valid, bus.in_desc};

    for (genvar i = 0; i < index; i++) begin : g_io
        assign d[0][i]         = bus.in_data[i];
        assign bus.out_data[i] = d[S][i];
`ifdef SORT_TAG_EN
        assign t[0][i]         = TAG_W'(i);
        assign bus.out_tag[i]  = t[S][i];
`endif
    end

    for (genvar k = 0; k < S; k++) begin : g_stage
        bitonic_stage #(
            .width (width),
            .index (index),
            .SIGNED(SIGNED),
            .TAG_W (TAG_W),
            .P     (stage_p(k)),
            .Q     (stage_q(k)),
            .L     (L)
        ) u_stage (
            .clk     (clk),
            .rst     (rst),
            .en      (en),
            .ctrl_in (ctrl[k]),
            .d_in    (d[k]),
`ifdef SORT_TAG_EN
            .tag_in  (t[k]),
            .tag_out (t[k+1]),
`endif
            .ctrl_out(ctrl[k+1]),
            .d_out   (d[k+1])
        );
    end

endmodule
